// File: rtl/axil_arbiter_wr_pkg.sv
// axil_arbiter_wr_pkg: shared types and constants for the AXI-lite write arbiter.
//   state_e     - arbiter FSM state (idle / transaction in flight)
//   RESP_OKAY   - AXI OKAY response code, driven on idle bresp lanes
//   idx_width() - index width for an N-entry vector (at least one bit)
package axil_arbiter_wr_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_arbiter_wr_rr_sel.sv
// axil_arbiter_wr_rr_sel: combinational round-robin priority select.
// Picks the first set request bit searching upward from (i_last + 1), wrapping.
//   i_req   - request vector, one bit per port
//   i_last  - index of the most recently served port
//   o_valid - at least one request is set
//   o_index - selected port index (0 when o_valid is low)
module axil_arbiter_wr_rr_sel
  import axil_arbiter_wr_pkg::*;
#(
  parameter int unsigned S_COUNT = 4,
  localparam int unsigned IdxW = idx_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0] i_req,
  input  logic [IdxW-1:0]    i_last,
  output logic               o_valid,
  output logic [IdxW-1:0]    o_index
);

  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    // Wrapped half (ports at or below i_last): lowest priority, smallest index wins.
    for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
      if (i_req[i] && (i <= int'(i_last))) begin
        o_valid = 1'b1;
        o_index = i[IdxW-1:0];
      end
    end
    // Ports above i_last override the wrapped half; again smallest index wins.
    for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
      if (i_req[i] && (i > int'(i_last))) begin
        o_valid = 1'b1;
        o_index = i[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_wr.sv
// axil_arbiter_wr: round-robin arbiter sharing one AXI-lite write master port
// among S_COUNT AXI-lite write slave ports. One transaction (AW + W + B) is in
// flight at a time; the grant is held from arbitration until the B handshake.
//   clk, rst_n      - clock, synchronous active-low reset
//   s_axil_aw*      - per-port write address channels (port i at slice i)
//   s_axil_w*       - per-port write data channels
//   s_axil_b*       - per-port write response channels
//   m_axil_aw*/w*/b*- shared master-side channels
module axil_arbiter_wr
  import axil_arbiter_wr_pkg::*;
#(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]          s_axil_awprot,
  input  logic [S_COUNT-1:0]            s_axil_awvalid,
  output logic [S_COUNT-1:0]            s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic [S_COUNT-1:0]            s_axil_wvalid,
  output logic [S_COUNT-1:0]            s_axil_wready,
  output logic [S_COUNT*2-1:0]          s_axil_bresp,
  output logic [S_COUNT-1:0]            s_axil_bvalid,
  input  logic [S_COUNT-1:0]            s_axil_bready,
  output logic [ADDR_WIDTH-1:0]         m_axil_awaddr,
  output logic [2:0]                    m_axil_awprot,
  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  output logic [DATA_WIDTH-1:0]         m_axil_wdata,
  output logic [STRB_WIDTH-1:0]         m_axil_wstrb,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready
);

  localparam int unsigned IdxW = idx_width(S_COUNT);

  state_e          r_state;
  logic [IdxW-1:0] r_grant;
  logic [IdxW-1:0] r_last;
  logic            r_aw_done;
  logic            r_w_done;

  logic            w_sel_valid;
  logic [IdxW-1:0] w_sel_idx;
  logic [S_COUNT-1:0] w_gnt_oh;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_b_en;
  logic            w_b_hs;

  logic [ADDR_WIDTH-1:0] w_awaddr_arr [S_COUNT];
  logic [2:0]            w_awprot_arr [S_COUNT];
  logic [DATA_WIDTH-1:0] w_wdata_arr  [S_COUNT];
  logic [STRB_WIDTH-1:0] w_wstrb_arr  [S_COUNT];

  for (genvar i = 0; i < S_COUNT; i++) begin : g_slice
    assign w_awaddr_arr[i] = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_awprot_arr[i] = s_axil_awprot[i*3 +: 3];
    assign w_wdata_arr[i]  = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_wstrb_arr[i]  = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
  end

  // Only awvalid requests a grant; a port presenting only W is never selected.
  axil_arbiter_wr_rr_sel #(
    .S_COUNT (S_COUNT)
  ) u_rr_sel (
    .i_req   (s_axil_awvalid),
    .i_last  (r_last),
    .o_valid (w_sel_valid),
    .o_index (w_sel_idx)
  );

  // One-hot of the granted port; all zero outside ACTIVE so every port is gated off.
  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < int'(S_COUNT); i++) begin
      if ((r_state == StActive) && (int'(r_grant) == i)) begin
        w_gnt_oh[i] = 1'b1;
      end
    end
  end

  assign m_axil_awaddr  = w_awaddr_arr[r_grant];
  assign m_axil_awprot  = w_awprot_arr[r_grant];
  assign m_axil_wdata   = w_wdata_arr[r_grant];
  assign m_axil_wstrb   = w_wstrb_arr[r_grant];

  assign m_axil_awvalid = (|(w_gnt_oh & s_axil_awvalid)) & ~r_aw_done;
  assign m_axil_wvalid  = (|(w_gnt_oh & s_axil_wvalid)) & ~r_w_done;
  assign s_axil_awready = w_gnt_oh & {S_COUNT{m_axil_awready & ~r_aw_done}};
  assign s_axil_wready  = w_gnt_oh & {S_COUNT{m_axil_wready & ~r_w_done}};

  assign w_aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_w_hs  = m_axil_wvalid & m_axil_wready;

  // B opens as soon as both AW and W are complete, including the cycle they complete.
  assign w_b_en        = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign m_axil_bready = (|(w_gnt_oh & s_axil_bready)) & w_b_en;
  assign s_axil_bvalid = w_gnt_oh & {S_COUNT{m_axil_bvalid & w_b_en}};
  assign w_b_hs        = m_axil_bvalid & m_axil_bready;

  always_comb begin
    s_axil_bresp = {S_COUNT{RESP_OKAY}};
    for (int i = 0; i < int'(S_COUNT); i++) begin
      if (w_gnt_oh[i]) begin
        s_axil_bresp[2*i +: 2] = m_axil_bresp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_grant   <= '0;
      r_last    <= IdxW'(S_COUNT - 1);
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_sel_valid) begin
            r_grant   <= w_sel_idx;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= StActive;
          end
        end
        StActive: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if (w_b_hs) begin
            r_last  <= r_grant;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
